// File: rtl/fishing_level_fsm.sv
// Game-state engine for the VGA fishing game: rod, line and fish
// coordinates plus status for NUM_LEVELS levels of fish.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   tick            one-clk game-update strobe; all state holds otherwise
//   up/left/right   hook and rod-move buttons
//   reel            reel magnitude; its top nibble sets the reel speed
//   rod_x, line_y   rod/line x and line tip y
//   fish_x, fish_y  fish left-edge x and centre y
//   level           current level (0 is deepest)
//   fish_visible    fish swimming or hooked
//   catching, win   high in CATCH / WIN
//   catch_pulse     one clk high after a hook
//   escape_pulse    one clk high after an escape
//
// Optional build macro FISH_ESCAPE_EN: a hooked fish escapes after
// ESCAPE_TICKS idle reel ticks. Undefined: escape_pulse is tied 0.

module fishing_level_fsm #(
    parameter int NUM_LEVELS   = 4,
    parameter int X_MIN        = 312,
    parameter int X_MAX        = 798,
    parameter int ROD_X_RST    = 450,
    parameter int FISH_X_START = 798,
    parameter int FISH_X_END   = 144,
    parameter int WATER_Y      = 155,
    parameter int SURFACE_Y    = 106,
    parameter int LEVEL0_Y     = 470,
    parameter int LEVEL_STEP   = 90,
    parameter int SPAWN_DELAY  = 400,
    parameter int FISH_SPEED   = 2,
    parameter int ROD_SPEED    = 3,
    parameter int DROP_SPEED   = 4,
    parameter int HIT_W0       = 15,
    parameter int HIT_H0       = 10,
    parameter int REEL_W       = 9,
    parameter int SLOW_THR     = 8,
    parameter int FAST_THR     = 9,
    parameter int ESCAPE_TICKS = 120
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          up,
    input  logic                          left,
    input  logic                          right,
    input  logic [REEL_W-1:0]             reel,
    output logic [9:0]                    rod_x,
    output logic [9:0]                    line_y,
    output logic [9:0]                    fish_x,
    output logic [9:0]                    fish_y,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic                          fish_visible,
    output logic                          catching,
    output logic                          win,
    output logic                          catch_pulse,
    output logic                          escape_pulse
);

    localparam int LW = $clog2(NUM_LEVELS);
    localparam int SW =
        (SPAWN_DELAY > 0) ? $clog2(SPAWN_DELAY + 1) : 1;

    localparam logic [1:0] S_FISH  = 2'd0;
    localparam logic [1:0] S_CATCH = 2'd1;
    localparam logic [1:0] S_WIN   = 2'd2;

    localparam logic [SW-1:0] SPAWN_MAX = SW'(SPAWN_DELAY);

    function automatic logic [9:0] sat10(input int v);
        if (v < 0)
            return 10'd0;
        if (v > 1023)
            return 10'd1023;
        return 10'(v);
    endfunction

    function automatic logic [9:0] lvl_y_of(input int l);
        return sat10(LEVEL0_Y - l * LEVEL_STEP);
    endfunction

    function automatic int half_win(input int w0, input int l);
        int w;
        w = w0 >> l;
        if (w < 1)
            w = 1;
        return w;
    endfunction

    logic [1:0]    state;
    logic [SW-1:0] spawn_cnt;

    logic [1:0]    n_state;
    logic [9:0]    n_rod;
    logic [9:0]    n_line;
    logic [9:0]    n_fx;
    logic [9:0]    n_fy;
    logic [LW-1:0] n_lvl;
    logic [SW-1:0] n_spawn;
    logic          n_cp;

    logic [9:0] lvl_y;
    logic [9:0] nxt_lvl_y;
    int         hit_w;
    int         hit_h;
    int         y_gap;
    logic       swim;
    logic       hit;
    logic       land;
    logic       last_lvl;
    logic       can_r;
    logic       can_l;
    logic [1:0] dy;
    logic [3:0] nib;
    logic       esc_fire;

    assign lvl_y     = lvl_y_of(int'(level));
    assign nxt_lvl_y = lvl_y_of(int'(level) + 1);
    assign hit_w     = half_win(HIT_W0, int'(level));
    assign hit_h     = half_win(HIT_H0, int'(level));
    assign last_lvl  = int'(level) == NUM_LEVELS - 1;

    assign swim = spawn_cnt == SPAWN_MAX;

    assign y_gap = (line_y >= fish_y)
                 ? int'(line_y) - int'(fish_y)
                 : int'(fish_y) - int'(line_y);

    assign hit = up && swim
              && (fish_x <= rod_x)
              && (int'(rod_x) <= int'(fish_x) + hit_w)
              && (y_gap <= hit_h);

    assign land  = int'(fish_y) < SURFACE_Y;
    assign can_r = int'(rod_x) + ROD_SPEED <= X_MAX;
    assign can_l = int'(rod_x) - ROD_SPEED >= X_MIN;

    assign nib = reel[REEL_W-1 -: 4];
    assign dy  = (int'(nib) > FAST_THR) ? 2'd2
               : (int'(nib) > SLOW_THR) ? 2'd1
               : 2'd0;

    generate
        if (REEL_W > 4) begin : g_reel_lsb
            logic unused_reel;
            assign unused_reel = ^reel[REEL_W-5:0];
        end
    endgenerate

    assign catching     = state == S_CATCH;
    assign win          = state == S_WIN;
    assign fish_visible = catching || (state == S_FISH && swim);

`ifdef FISH_ESCAPE_EN
    logic [9:0] idle_cnt;

    // Escape only counts reel-idle ticks; landing wins a tie.
    assign esc_fire = (state == S_CATCH) && !land && (dy == 2'd0)
                   && (int'(idle_cnt) + 1 >= ESCAPE_TICKS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt     <= 10'd0;
            escape_pulse <= 1'b0;
        end else begin
            escape_pulse <= tick && esc_fire;
            if (tick) begin
                if (state != S_CATCH || land ||
                    dy != 2'd0 || esc_fire)
                    idle_cnt <= 10'd0;
                else
                    idle_cnt <= idle_cnt + 10'd1;
            end
        end
    end
`else
    assign esc_fire     = 1'b0;
    assign escape_pulse = 1'b0;
`endif

    always_comb begin
        n_state = state;
        n_rod   = rod_x;
        n_line  = line_y;
        n_fx    = fish_x;
        n_fy    = fish_y;
        n_lvl   = level;
        n_spawn = spawn_cnt;
        n_cp    = 1'b0;
        unique case (1'b1)
            (state == S_FISH): begin
                n_fy = lvl_y;
                if (hit) begin
                    n_state = S_CATCH;
                    n_cp    = 1'b1;
                    n_fx    = rod_x;
                end else begin
                    if (int'(line_y) + DROP_SPEED > int'(lvl_y))
                        n_line = lvl_y;
                    else
                        n_line = sat10(int'(line_y) + DROP_SPEED);
                    if (right && can_r)
                        n_rod = sat10(int'(rod_x) + ROD_SPEED);
                    else if (left && can_l)
                        n_rod = sat10(int'(rod_x) - ROD_SPEED);
                    if ((left || right) && spawn_cnt < SPAWN_MAX)
                        n_spawn = spawn_cnt + SW'(1);
                    if (swim) begin
                        if (int'(fish_x) - FISH_SPEED <= FISH_X_END) begin
                            n_fx    = 10'(FISH_X_START);
                            n_spawn = '0;
                        end else begin
                            n_fx = sat10(int'(fish_x) - FISH_SPEED);
                        end
                    end
                end
            end
            (state == S_CATCH): begin
                if (land) begin
                    // The landing tick discards this tick's reel step.
                    if (last_lvl) begin
                        n_state = S_WIN;
                    end else begin
                        n_state = S_FISH;
                        n_lvl   = level + LW'(1);
                        n_fx    = 10'(FISH_X_START);
                        n_fy    = nxt_lvl_y;
                        n_spawn = '0;
                    end
                end else if (esc_fire) begin
                    n_state = S_FISH;
                    n_fx    = 10'(FISH_X_START);
                    n_fy    = lvl_y;
                    n_spawn = '0;
                end else begin
                    n_fx   = rod_x;
                    n_fy   = sat10(int'(fish_y) - int'(dy));
                    n_line = sat10(int'(line_y) - int'(dy));
                end
            end
            (state == S_WIN): begin
                // Restart keeps the rod where the player left it.
                if (left || right) begin
                    n_state = S_FISH;
                    n_line  = 10'(WATER_Y);
                    n_fx    = 10'(FISH_X_START);
                    n_fy    = 10'(LEVEL0_Y);
                    n_lvl   = '0;
                    n_spawn = '0;
                end
            end
            default: begin
                n_state = S_FISH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FISH;
            rod_x       <= 10'(ROD_X_RST);
            line_y      <= 10'(WATER_Y);
            fish_x      <= 10'(FISH_X_START);
            fish_y      <= 10'(LEVEL0_Y);
            level       <= '0;
            spawn_cnt   <= '0;
            catch_pulse <= 1'b0;
        end else begin
            catch_pulse <= tick && n_cp;
            if (tick) begin
                state     <= n_state;
                rod_x     <= n_rod;
                line_y    <= n_line;
                fish_x    <= n_fx;
                fish_y    <= n_fy;
                level     <= n_lvl;
                spawn_cnt <= n_spawn;
            end
        end
    end

endmodule
